// File: rtl/rv32i_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// opcode classes and ALU operand/operation selects.
package rv32i_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned SEL_W = 2;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL
  } opclass_e;

  typedef enum logic [SEL_W-1:0] {
    SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11
  } alu_src_a_e;

  typedef enum logic [SEL_W-1:0] {
    SRCB_RS2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10
  } alu_src_b_e;

  typedef enum logic [SEL_W-1:0] {
    ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/multicycle_ctrl_opclass_decode.sv
// Combinational opcode-to-class mapping; anything unrecognised is ILLEGAL.
module opclass_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls_c
);

  always_comb begin
    cls_c = C_ILLEGAL;
    case (opcode)
      OPC_R:      cls_c = C_R;
      OPC_IALU:   cls_c = C_IALU;
      OPC_LUI:    cls_c = C_LUI;
      OPC_LOAD:   cls_c = C_LOAD;
      OPC_STORE:  cls_c = C_STORE;
      OPC_BRANCH: cls_c = C_BRANCH;
      default:    cls_c = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback and
// drives the datapath enables and selects from state plus the latched class.
module multicycle_ctrl
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       iord,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal
);

  state_e     state, state_nxt;
  opclass_e   cls_q;
  opclass_e   cls_dec;
  logic [2:0] cls_raw;

  opclass_decode u_opclass_decode (
    .opcode (opcode),
    .cls_c  (cls_raw)
  );

  assign cls_dec = opclass_e'(cls_raw);

  // State register and class latch; the class is captured at the end of DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_START;
      cls_q <= C_R;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls_q <= cls_dec;
    end
  end

  // Next-state and output decode; outputs follow the state register directly
  // so an asynchronous reset drops memory strobes within the same cycle.
  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_START: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_nxt = (cls_dec == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        case (cls_q)
          C_R: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
            state_nxt = S_WB;
          end
          C_IALU: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_nxt = S_WB;
          end
          C_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            state_nxt = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_nxt = S_MEM;
          end
          C_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_TRAP;
        endcase
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_LOAD) begin
            state_nxt = S_WB;
          end else begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_TRAP: illegal = 1'b1;

      default: state_nxt = S_START;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model
// with per-cycle output comparison, directed literal cases and random traffic.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg;
  logic       iord, pc_src, retire, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .iord       (iord),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .retire     (retire),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Output vector layout: pcw irw rw mrd mwr m2r iord pcsrc a[2] b[2] op[2] ret ill
  logic [15:0] dv;
  assign dv = {pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
               iord, pc_src, alu_src_a, alu_src_b, alu_op, retire, illegal};

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LUI = 7'b0110111;
  localparam logic [6:0] O_LD = 7'b0000011, O_ST = 7'b0100011, O_BR = 7'b1100011;

  localparam int CL_R = 0, CL_I = 1, CL_LUI = 2, CL_LD = 3, CL_ST = 4, CL_BR = 5, CL_ILL = 6;
  localparam int K_START = 0, K_FETCH = 1, K_DECODE = 2, K_EXEC = 3, K_MEM = 4, K_WB = 5, K_TRAP = 6;

  int checks = 0;
  int errors = 0;

  // Model of the instruction in flight: current step, steps still to run.
  int k = K_START;
  int cls = CL_R;
  int plan[$];
  int cyc = 0;
  int waits = 0;
  int rw_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      O_R:     return CL_R;
      O_I:     return CL_I;
      O_LUI:   return CL_LUI;
      O_LD:    return CL_LD;
      O_ST:    return CL_ST;
      O_BR:    return CL_BR;
      default: return CL_ILL;
    endcase
  endfunction

  function automatic int base_cycles(input int c);
    if (c == CL_BR) return 3;
    if (c == CL_LD) return 5;
    return 4;
  endfunction

  function automatic logic [15:0] expect_out(input int kk, input int c, input logic mr, input logic z);
    logic pcw, irw, rw, mrd, mwr, m2r, io, ps, ret, ill;
    logic [1:0] a, b, op;
    {pcw, irw, rw, mrd, mwr, m2r, io, ps, ret, ill} = '0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (kk)
      K_FETCH:  begin mrd = 1'b1; b = 2'b01; irw = mr; pcw = mr; end
      K_DECODE: begin a = 2'b01; b = 2'b10; end
      K_EXEC: begin
        if (c == CL_R)                 begin a = 2'b10; op = 2'b10; end
        else if (c == CL_I)            begin a = 2'b10; b = 2'b10; op = 2'b10; end
        else if (c == CL_LUI)          begin a = 2'b11; b = 2'b10; end
        else if (c == CL_LD || c == CL_ST) begin a = 2'b10; b = 2'b10; end
        else if (c == CL_BR)           begin a = 2'b10; op = 2'b01; ps = 1'b1; pcw = z; ret = 1'b1; end
      end
      K_MEM: begin
        io = 1'b1; mrd = (c == CL_LD); mwr = (c == CL_ST); ret = (c == CL_ST) && mr;
      end
      K_WB:   begin rw = 1'b1; m2r = (c == CL_LD); ret = 1'b1; end
      K_TRAP: ill = 1'b1;
      default: ;
    endcase
    return {pcw, irw, rw, mrd, mwr, m2r, io, ps, a, b, op, ret, ill};
  endfunction

  task automatic compare();
    logic [15:0] e;
    e = expect_out(k, cls, mem_ready, zero);
    chk($sformatf("outputs_step%0d", k), 32'(dv), 32'(e));
    chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
  endtask

  // Move the model to the step the DUT will be in after the coming edge.
  task automatic advance();
    logic [15:0] e;
    cyc++;
    if (reg_write) rw_cnt++;
    if ((k == K_FETCH || k == K_MEM) && !mem_ready) begin
      waits++;
      return;
    end
    if (k == K_TRAP) return;
    e = expect_out(k, cls, mem_ready, zero);
    if (e[1]) begin
      chk($sformatf("instr_cycles_cls%0d", cls), 32'(cyc), 32'(base_cycles(cls) + waits));
      chk("reg_write_once", 32'(rw_cnt <= 1), 32'd1);
    end
    if (k == K_DECODE) begin
      cls = classify(opcode);
      case (cls)
        CL_R, CL_I, CL_LUI: begin plan.push_back(K_EXEC); plan.push_back(K_WB); end
        CL_LD: begin plan.push_back(K_EXEC); plan.push_back(K_MEM); plan.push_back(K_WB); end
        CL_ST: begin plan.push_back(K_EXEC); plan.push_back(K_MEM); end
        CL_BR: plan.push_back(K_EXEC);
        default: plan.push_back(K_TRAP);
      endcase
    end
    if (plan.size() == 0) begin
      plan.push_back(K_FETCH);
      plan.push_back(K_DECODE);
      cyc = 0; waits = 0; rw_cnt = 0;
    end
    k = plan.pop_front();
  endtask

  task automatic cycle(input logic mr, input logic z, input logic [6:0] opc);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero = z;
    opcode = opc;
    @(negedge clk);
    compare();
    advance();
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_async"}, 32'(dv), 32'd0);
    k = K_START;
    plan.delete();
    cyc = 0; waits = 0; rw_cnt = 0; cls = CL_R;
    @(posedge clk);
    #1;
    chk({tag, "_held"}, 32'(dv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal [6];
    logic [6:0] cur_opc;
    int trap_cycles;
    legal = '{O_R, O_I, O_LUI, O_LD, O_ST, O_BR};

    do_reset("reset0");

    // R with an opcode change during EXEC that must be ignored.
    cycle(1'b1, 1'b0, O_R);  chk("r_fetch", 32'(dv), 32'h0000D010);
    cycle(1'b1, 1'b0, O_R);  chk("r_decode", 32'(dv), 32'h00000060);
    cycle(1'b1, 1'b0, O_LD); chk("r_exec_opc_changed", 32'(dv), 32'h00000088);
    cycle(1'b1, 1'b0, O_ST); chk("r_wb", 32'(dv), 32'h00002002);

    // LOAD with two memory wait cycles; seventh cycle is WB.
    cycle(1'b1, 1'b0, O_LD); chk("ld_fetch", 32'(dv), 32'h0000D010);
    cycle(1'b1, 1'b0, O_LD); chk("ld_decode", 32'(dv), 32'h00000060);
    cycle(1'b1, 1'b0, O_LD); chk("ld_exec", 32'(dv), 32'h000000A0);
    cycle(1'b0, 1'b0, O_LD); chk("ld_mem_wait1", 32'(dv), 32'h00001200);
    cycle(1'b0, 1'b0, O_LD); chk("ld_mem_wait2", 32'(dv), 32'h00001200);
    cycle(1'b1, 1'b0, O_LD); chk("ld_mem_done", 32'(dv), 32'h00001200);
    cycle(1'b1, 1'b0, O_LD); chk("ld_wb", 32'(dv), 32'h00002402);

    // BRANCH taken then not taken.
    cycle(1'b1, 1'b0, O_BR); chk("br1_fetch", 32'(dv), 32'h0000D010);
    cycle(1'b1, 1'b1, O_BR); chk("br1_decode", 32'(dv), 32'h00000060);
    cycle(1'b1, 1'b1, O_BR); chk("br1_exec_taken", 32'(dv), 32'h00008186);
    cycle(1'b1, 1'b0, O_BR); chk("br2_fetch", 32'(dv), 32'h0000D010);
    cycle(1'b1, 1'b0, O_BR); chk("br2_decode", 32'(dv), 32'h00000060);
    cycle(1'b1, 1'b0, O_BR); chk("br2_exec_not_taken", 32'(dv), 32'h00000186);

    // STORE interrupted by reset while waiting in MEM.
    cycle(1'b1, 1'b0, O_ST); chk("st_fetch", 32'(dv), 32'h0000D010);
    cycle(1'b1, 1'b0, O_ST); chk("st_decode", 32'(dv), 32'h00000060);
    cycle(1'b1, 1'b0, O_ST); chk("st_exec", 32'(dv), 32'h000000A0);
    cycle(1'b0, 1'b0, O_ST); chk("st_mem_wait", 32'(dv), 32'h00000A00);
    do_reset("st_reset");
    cycle(1'b1, 1'b0, O_R);  chk("post_reset_fetch", 32'(dv), 32'h0000D010);

    // Illegal opcode traps and stays trapped regardless of mem_ready.
    cycle(1'b1, 1'b0, 7'h7F); chk("ill_decode", 32'(dv), 32'h00000060);
    cycle(1'b1, 1'b0, 7'h7F); chk("ill_trap", 32'(dv), 32'h00000001);
    cycle(1'b0, 1'b1, O_R);   chk("ill_trap_mr0", 32'(dv), 32'h00000001);
    cycle(1'b1, 1'b0, O_LD);  chk("ill_trap_mr1", 32'(dv), 32'h00000001);
    do_reset("ill_reset");

    // Random traffic against the model.
    cur_opc = O_R;
    trap_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      logic [6:0] drv;
      if (k == K_TRAP) begin
        trap_cycles++;
        if (trap_cycles > 3) begin
          do_reset("rand_reset");
          trap_cycles = 0;
          continue;
        end
      end
      if (k == K_FETCH) begin
        int r;
        r = int'($urandom_range(0, 39));
        cur_opc = (r == 0) ? 7'($urandom) : legal[r % 6];
      end
      drv = cur_opc;
      if (k != K_FETCH && k != K_DECODE && $urandom_range(0, 3) == 0) drv = 7'($urandom);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), drv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
